req_ack_arbiter: RTL and testbench

- Round-robin scheduler that shares one pulse-request/acknowledge responder among N_REQ clients.
- Issues single-cycle `req` pulses to the responder and enforces a minimum req-to-req spacing.
- Tracks the outstanding acknowledge with a timeout.
- Returns a one-cycle done or error pulse to the owning client, and keeps running req/ack counters for checking.

---
 rtl/req_ack_arbiter.sv | 177 +++++++++++++++++
 tb/tb_req_ack_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/req_ack_arbiter.sv
// req_ack_arbiter
// Round-robin scheduler that shares one pulse-request/acknowledge responder
// among N_REQ clients. It issues a single-cycle req pulse, enforces a minimum
// spacing between req pulses, waits for the ack rising edge with a timeout,
// and returns a one-cycle done or err pulse to the client that owns the
// transaction. Running counters of issued reqs and accepted acks are kept.
//
// Ports:
//   clk           clock, all logic on posedge
//   rst           asynchronous active-high reset
//   client_valid  [N_REQ] level request per client
//   client_grant  [N_REQ] one-hot pulse in the cycle that client's req is issued
//   client_done   [N_REQ] one-hot pulse when that client's ack is accepted
//   client_err    [N_REQ] one-hot pulse when that client's ack timed out
//   req           request pulse to the responder
//   ack           responder acknowledge (rising edge only is meaningful)
//   busy          high while a transaction is outstanding (FSM in WAIT)
//   stray_ack     pulse on an ack rising edge that no WAIT cycle accepted
//   reqs_seen     [CNT_W] issued req count, wraps
//   acks_seen     [CNT_W] accepted ack count, wraps
//
// Handshake: a client raises client_valid and holds it until it sees its
// client_grant bit; dropping it earlier simply withdraws the request. The
// responder side is pulse based: one req pulse, answered by one ack rising
// edge no earlier than the cycle after req and no later than ACK_TIMEOUT
// cycles after req.
module req_ack_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MIN_GAP     = 8,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] client_valid,
  output logic [N_REQ-1:0] client_grant,
  output logic [N_REQ-1:0] client_done,
  output logic [N_REQ-1:0] client_err,
  output logic             req,
  input  logic             ack,
  output logic             busy,
  output logic             stray_ack,
  output logic [CNT_W-1:0] reqs_seen,
  output logic [CNT_W-1:0] acks_seen
);

  localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W  = $clog2(MIN_GAP + 1);
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(MIN_GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_RST  = GAP_W'(MIN_GAP);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(ACK_TIMEOUT);
  localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(N_REQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_d;

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  sel;
  logic              sel_valid;
  logic [GAP_W-1:0]  gap_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              ack_q;
  logic              ack_rise;
  logic              gap_ok;
  logic              issue;
  logic              accept;
  logic              expire;

  assign ack_rise = ack & ~ack_q;
  assign gap_ok   = (gap_cnt >= GAP_MAX);

  // Round-robin pick: scan from ptr+N down to ptr+1 so the last hit written
  // is the first valid client cyclically after the pointer.
  always_comb begin
    logic [PTR_W-1:0] idx;
    sel       = ptr;
    sel_valid = 1'b0;
    idx       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (client_valid[idx]) begin
        sel       = idx;
        sel_valid = 1'b1;
      end
    end
  end

  // Next-state logic. In WAIT, wait_cnt equals the number of cycles since
  // the req cycle; the req cycle itself (wait_cnt == 0) never accepts an ack,
  // so an ack landing together with req is reported as stray. An ack in the
  // very cycle the timeout expires wins over the timeout.
  always_comb begin
    state_d = state;
    issue   = 1'b0;
    accept  = 1'b0;
    expire  = 1'b0;
    case (state)
      S_IDLE: begin
        if (gap_ok && sel_valid) begin
          issue   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_rise && (wait_cnt != '0)) begin
          accept  = 1'b1;
          state_d = S_IDLE;
        end else if (wait_cnt == WAIT_MAX) begin
          expire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= PTR_RST;
      owner        <= '0;
      gap_cnt      <= GAP_RST;
      wait_cnt     <= '0;
      ack_q        <= 1'b0;
      req          <= 1'b0;
      busy         <= 1'b0;
      stray_ack    <= 1'b0;
      client_grant <= '0;
      client_done  <= '0;
      client_err   <= '0;
      reqs_seen    <= '0;
      acks_seen    <= '0;
    end else begin
      state     <= state_d;
      ack_q     <= ack;
      req       <= issue;
      busy      <= (state_d == S_WAIT);
      stray_ack <= ack_rise & ~accept;

      client_grant <= issue  ? (N_REQ'(1) << sel)   : '0;
      client_done  <= accept ? (N_REQ'(1) << owner) : '0;
      client_err   <= expire ? (N_REQ'(1) << owner) : '0;

      if (issue) begin
        owner     <= sel;
        ptr       <= sel;
        reqs_seen <= reqs_seen + CNT_W'(1);
      end

      if (accept) begin
        acks_seen <= acks_seen + CNT_W'(1);
      end

      // Spacing counter runs in every state and saturates once the
      // minimum req-to-req gap has been met.
      if (issue) begin
        gap_cnt <= '0;
      end else if (gap_cnt < GAP_MAX) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end

      if (issue) begin
        wait_cnt <= '0;
      end else if ((state == S_WAIT) && (wait_cnt != WAIT_MAX)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_req_ack_arbiter.sv
// Directed testbench for req_ack_arbiter (N_REQ=4, MIN_GAP=8, ACK_TIMEOUT=15).
// Inputs change and outputs are sampled 1 ns after the rising clock edge.
module tb_req_ack_arbiter;

  localparam int N   = 4;
  localparam int GAP = 8;
  localparam int TO  = 15;
  localparam int W   = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] client_valid = '0;
  logic         ack = 1'b0;
  logic [N-1:0] client_grant;
  logic [N-1:0] client_done;
  logic [N-1:0] client_err;
  logic         req;
  logic         busy;
  logic         stray_ack;
  logic [W-1:0] reqs_seen;
  logic [W-1:0] acks_seen;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  req_ack_arbiter #(
    .N_REQ(N), .MIN_GAP(GAP), .ACK_TIMEOUT(TO), .CNT_W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .client_valid(client_valid),
    .client_grant(client_grant),
    .client_done(client_done),
    .client_err(client_err),
    .req(req),
    .ack(ack),
    .busy(busy),
    .stray_ack(stray_ack),
    .reqs_seen(reqs_seen),
    .acks_seen(acks_seen)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   32'(req), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_stray"}, 32'(stray_ack), 0);
    chk({tag, "_grant"}, 32'(client_grant), 0);
    chk({tag, "_done"},  32'(client_done), 0);
    chk({tag, "_err"},   32'(client_err), 0);
    chk({tag, "_reqs"},  reqs_seen, 0);
    chk({tag, "_acks"},  acks_seen, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    chk_all_zero(tag);
    tick();
    rst = 1'b0;
  endtask

  // Bounded wait for the next req pulse; returns its cycle number or -1.
  task automatic wait_req(input string tag, output int at);
    at = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (req === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk({tag, "_req_seen"}, 32'(at >= 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2, prev, rel, c;

    // ---- reset values, single client with ack 4 cycles after req
    do_reset("rst0");
    rel = cyc;
    client_valid = 4'b0001;
    wait_req("t1", r);
    chk("t1_latency", 32'(r - rel), 1);
    chk("t1_grant", 32'(client_grant), 32'b0001);
    chk("t1_busy_req", 32'(busy), 1);
    chk("t1_reqs", reqs_seen, 1);
    client_valid = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_busy", 32'(busy), 1);
      chk("t1_req_low", 32'(req), 0);
      chk("t1_no_done", 32'(client_done), 0);
    end
    tick();
    ack = 1'b1;
    chk("t1_busy4", 32'(busy), 1);
    tick();
    ack = 1'b0;
    chk("t1_done", 32'(client_done), 32'b0001);
    chk("t1_acks", acks_seen, 1);
    chk("t1_reqs_end", reqs_seen, 1);
    chk("t1_idle", 32'(busy), 0);

    // ---- all clients valid: rotation 0,1,2,3,0 and 8-cycle req spacing
    do_reset("rst1");
    client_valid = 4'b1111;
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      wait_req("t2", r);
      chk("t2_grant", 32'(client_grant), 32'(1 << (i % 4)));
      if (i > 0) chk("t2_spacing", 32'(r - prev), 8);
      prev = r;
      tick(); tick(); tick();
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("t2_done", 32'(client_done), 32'(1 << (i % 4)));
    end
    chk("t2_reqs", reqs_seen, 5);
    chk("t2_acks", acks_seen, 5);

    // ---- timeout: client 2 never acked
    client_valid = 4'b0100;
    wait_req("t3", r);
    chk("t3_spacing", 32'(r - prev), 8);
    chk("t3_grant", 32'(client_grant), 32'b0100);
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk("t3_no_err", 32'(client_err), 0);
      chk("t3_busy", 32'(busy), 1);
    end
    tick();
    chk("t3_err", 32'(client_err), 32'b0100);
    chk("t3_no_done", 32'(client_done), 0);
    chk("t3_idle", 32'(busy), 0);
    chk("t3_acks", acks_seen, 5);
    chk("t3_reqs", reqs_seen, 6);
    tick();
    chk("t3_err_once", 32'(client_err), 0);
    chk("t3_next_req", 32'(req), 1);
    chk("t3_next_grant", 32'(client_grant), 32'b0100);

    // ---- ack coinciding with req is stray; a later ack is accepted
    ack = 1'b1;
    client_valid = 4'b0000;
    tick();
    chk("t4_stray_req", 32'(stray_ack), 1);
    chk("t4_no_done", 32'(client_done), 0);
    ack = 1'b0;
    tick();
    ack = 1'b1;
    chk("t4_stray_clr", 32'(stray_ack), 0);
    tick();
    ack = 1'b0;
    chk("t4_done", 32'(client_done), 32'b0100);
    chk("t4_acks", acks_seen, 6);
    chk("t4_no_stray", 32'(stray_ack), 0);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t4_stray_idle", 32'(stray_ack), 1);
    chk("t4_idle_no_done", 32'(client_done), 0);
    chk("t4_idle_acks", acks_seen, 6);
    tick();
    chk("t4_stray_end", 32'(stray_ack), 0);

    // ---- ack held high across two transactions: done then err
    do_reset("rst2");
    client_valid = 4'b0001;
    wait_req("t5a", r);
    chk("t5a_grant", 32'(client_grant), 32'b0001);
    tick();
    tick();
    ack = 1'b1;
    tick();
    chk("t5a_done", 32'(client_done), 32'b0001);
    chk("t5a_acks", acks_seen, 1);
    wait_req("t5b", r2);
    chk("t5b_spacing", 32'(r2 - r), 8);
    chk("t5b_grant", 32'(client_grant), 32'b0001);
    client_valid = 4'b0000;
    for (int k = 1; k <= TO; k++) begin
      tick();
      chk("t5b_no_done", 32'(client_done), 0);
    end
    tick();
    chk("t5b_err", 32'(client_err), 32'b0001);
    chk("t5b_acks", acks_seen, 1);
    chk("t5b_reqs", reqs_seen, 2);
    ack = 1'b0;

    // ---- reset while busy, ack rising after release, then contention
    client_valid = 4'b0001;
    wait_req("t6a", r);
    tick();
    tick();
    chk("t6_busy_before", 32'(busy), 1);
    client_valid = 4'b0000;
    c = cyc;
    rst = 1'b1;
    #1;
    chk_all_zero("t6_async");
    tick();
    rst = 1'b0;
    chk("t6_no_err1", 32'(client_err), 0);
    tick();
    ack = 1'b1;
    chk("t6_no_done2", 32'(client_done), 0);
    tick();
    chk("t6_stray", 32'(stray_ack), 1);
    chk("t6_no_done", 32'(client_done), 0);
    chk("t6_no_err", 32'(client_err), 0);
    ack = 1'b0;
    client_valid = 4'b1001;
    wait_req("t6b", r);
    chk("t6_req_time", 32'(r - c), 4);
    chk("t6_grant", 32'(client_grant), 32'b0001);
    chk("t6_reqs", reqs_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
